// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin UART transmitter with its own baud counter and frame FSM.
// Define UART_PARITY_EN to insert an even-parity bit after D7.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 1
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iReqA,
  input  logic [7:0] iDataA,
  output logic       oAckA,
  input  logic       iReqB,
  input  logic [7:0] iDataB,
  output logic       oAckB,
  output logic       oTx,
  output logic       oBusy,
  output logic       oOwner
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitIdx;
  logic             r_stopIdx;
  logic             r_owner;
  logic             r_ackA;
  logic             r_ackB;
  logic             r_tx;
`ifdef UART_PARITY_EN
  logic             r_parity;
`endif

  logic w_grantA;
  logic w_grantB;
  logic w_bitEnd;

  // r_owner doubles as the round-robin pointer: a tie goes to the other requester.
  assign w_grantB = iReqB && (!iReqA || !r_owner);
  assign w_grantA = iReqA && !w_grantB;
  assign w_bitEnd = (r_cnt == CNT_MAX);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bitIdx  <= '0;
      r_stopIdx <= 1'b0;
      r_owner   <= 1'b1;
      r_ackA    <= 1'b0;
      r_ackB    <= 1'b0;
      r_tx      <= 1'b1;
`ifdef UART_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_ackA <= 1'b0;
      r_ackB <= 1'b0;
      if (r_state != S_IDLE) begin
        r_cnt <= w_bitEnd ? '0 : r_cnt + CNT_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grantA || w_grantB) begin
            r_state   <= S_START;
            r_tx      <= 1'b0;
            r_owner   <= w_grantB;
            r_ackA    <= w_grantA;
            r_ackB    <= w_grantB;
            r_shift   <= w_grantB ? iDataB : iDataA;
            r_bitIdx  <= '0;
            r_stopIdx <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity  <= w_grantB ? ^iDataB : ^iDataA;
`endif
          end
        end
        S_START: begin
          if (w_bitEnd) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
        S_DATA: begin
          if (w_bitEnd) begin
            if (r_bitIdx == 3'd7) begin
`ifdef UART_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_tx     <= r_shift[0];
              r_shift  <= {1'b0, r_shift[7:1]};
            end
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (w_bitEnd) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bitEnd) begin
            if ((STOP_BITS == 1) || r_stopIdx) begin
              r_state <= S_IDLE;
            end else begin
              r_stopIdx <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign oAckA  = r_ackA;
  assign oAckB  = r_ackB;
  assign oTx    = r_tx;
  assign oBusy  = (r_state != S_IDLE);
  assign oOwner = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table vectors, hand sequences and random rounds
// checked against a queue-based model of arbitration and frame waveforms.
module tb_uart_tx_arbiter;

  localparam int CPB   = 4;
  localparam int STOPB = 1;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 10 + PAR + STOPB - 1;
  localparam int FRAME = NBITS * CPB;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iReqA = 1'b0;
  logic [7:0] iDataA = 8'h00;
  logic       iReqB = 1'b0;
  logic [7:0] iDataB = 8'h00;
  logic       oAckA;
  logic       oAckB;
  logic       oTx;
  logic       oBusy;
  logic       oOwner;

  int checks = 0;
  int failures = 0;

  logic [7:0] qA[$];
  logic [7:0] qB[$];
  bit lastOwner = 1'b1;
  bit expectGap = 1'b0;

  typedef struct {
    bit         reqA;
    logic [7:0] dA;
    bit         reqB;
    logic [7:0] dB;
    bit         expOwner;
  } vec_t;

  vec_t vecs[8];

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOPB)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iReqA(iReqA), .iDataA(iDataA), .oAckA(oAckA),
    .iReqB(iReqB), .iDataB(iDataB), .oAckB(oAckB),
    .oTx(oTx), .oBusy(oBusy), .oOwner(oOwner)
  );

  always #5 iClk = ~iClk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog act=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line level for frame bit slot idx of byte d.
  function automatic logic expBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR == 1 && idx == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic applyStimulus();
    iReqA = (qA.size() > 0);
    if (qA.size() > 0) iDataA = qA[0];
    iReqB = (qB.size() > 0);
    if (qB.size() > 0) iDataB = qB[0];
  endtask

  // Waits for the next grant, checks it against the model and checks the full frame waveform.
  task automatic checkNextFrame(output bit obsOwner);
    bit         expOwner;
    logic [7:0] expByte;
    int         waited;
    bit         gotAck;
    expOwner = (qA.size() > 0 && qB.size() > 0) ? ~lastOwner : (qB.size() > 0);
    expByte  = expOwner ? qB[0] : qA[0];
    gotAck   = 1'b0;
    waited   = 0;
    while (!gotAck && waited < 3 * FRAME) begin
      @(negedge iClk);
      waited++;
      gotAck = oAckA | oAckB;
    end
    obsOwner = oOwner;
    if (!gotAck) begin
      checkOutput("ackTimeout", 32'(waited), 32'(0));
      qA.delete();
      qB.delete();
      iReqA = 1'b0;
      iReqB = 1'b0;
      return;
    end
    if (expectGap) checkOutput("idleGap", 32'(waited), 32'(1));
    checkOutput("ack", 32'({oAckA, oAckB}), expOwner ? 32'(1) : 32'(2));
    checkOutput("owner", 32'(oOwner), 32'(expOwner));
    if (expOwner) begin
      void'(qB.pop_front());
      if (qB.size() > 0) iDataB = qB[0];
      else iReqB = 1'b0;
    end else begin
      void'(qA.pop_front());
      if (qA.size() > 0) iDataA = qA[0];
      else iReqA = 1'b0;
    end
    lastOwner = expOwner;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) begin
        @(negedge iClk);
        checkOutput("ackPulse", 32'({oAckA, oAckB}), 32'(0));
      end
      checkOutput("txBit", 32'(oTx), 32'(expBit(expByte, c / CPB)));
      checkOutput("busy", 32'(oBusy), 32'(1));
    end
    @(negedge iClk);
    checkOutput("idleBusy", 32'(oBusy), 32'(0));
    checkOutput("idleTx", 32'(oTx), 32'(1));
    expectGap = (qA.size() + qB.size() > 0);
  endtask

  task automatic runRound();
    bit owner;
    expectGap = 1'b0;
    applyStimulus();
    while (qA.size() + qB.size() > 0) checkNextFrame(owner);
  endtask

  initial begin
    bit owner;
    bit first;
    int waited;

    vecs[0] = '{1'b1, 8'h12, 1'b1, 8'h34, 1'b0};
    vecs[1] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1};
    vecs[3] = '{1'b1, 8'h3C, 1'b1, 8'hC3, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 8'hFF, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{1'b1, 8'h07, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 8'h03, 1'b0, 8'h00, 1'b0};

    // Reset state while held.
    repeat (3) @(negedge iClk);
    checkOutput("rstTx", 32'(oTx), 32'(1));
    checkOutput("rstBusy", 32'(oBusy), 32'(0));
    checkOutput("rstAck", 32'({oAckA, oAckB}), 32'(0));
    checkOutput("rstOwner", 32'(oOwner), 32'(1));
    iRst_n = 1'b1;
    @(negedge iClk);

    // Table vectors: first owner is a fixed expectation, rest follows the model.
    foreach (vecs[i]) begin
      qA.delete();
      qB.delete();
      if (vecs[i].reqA) qA.push_back(vecs[i].dA);
      if (vecs[i].reqB) qB.push_back(vecs[i].dB);
      expectGap = 1'b0;
      applyStimulus();
      first = 1'b1;
      while (qA.size() + qB.size() > 0) begin
        checkNextFrame(owner);
        if (first) checkOutput("vecOwner", 32'(owner), 32'(vecs[i].expOwner));
        first = 1'b0;
      end
    end

    // Held request with new data after each ack: three frames in order.
    qA = '{8'h01, 8'h02, 8'h03};
    runRound();

    // Reset during data bit 3 of 8'hF0, then the held request is resent in full.
    qA = '{8'hF0};
    applyStimulus();
    waited = 0;
    while (!oAckA && waited < 3 * FRAME) begin
      @(negedge iClk);
      waited++;
    end
    checkOutput("midAck", 32'(oAckA), 32'(1));
    repeat (4 * CPB + 1) @(negedge iClk);
    checkOutput("midTxBit3", 32'(oTx), 32'(0));
    #2 iRst_n = 1'b0;
    #1;
    checkOutput("asyncTx", 32'(oTx), 32'(1));
    checkOutput("asyncBusy", 32'(oBusy), 32'(0));
    @(negedge iClk);
    iRst_n = 1'b1;
    lastOwner = 1'b1;
    expectGap = 1'b0;
    checkNextFrame(owner);

    // Random rounds against the model.
    for (int r = 0; r < 20; r++) begin
      int na;
      int nb;
      qA.delete();
      qB.delete();
      na = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      for (int k = 0; k < na; k++) qA.push_back(8'($urandom_range(0, 255)));
      for (int k = 0; k < nb; k++) qB.push_back(8'($urandom_range(0, 255)));
      runRound();
      repeat ($urandom_range(0, 3)) @(negedge iClk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
